lr_col_merge: RTL and testbench

Column-merging join that rebuilds the interleaved left/right pixel stream from separate left and right 32-bit AXI4-Stream streams. Each input word carries 4 8-bit pixels. The block decimates each word horizontally by 2 and packs the two surviving left and two surviving right pixels into one interleaved LR word. It sits at the output of the per-camera processing chains, ahead of the DMA/output path. It also keeps the two streams frame-aligned with a tuser/tlast resync state machine.

---
 rtl/lr_col_merge.sv | 173 +++++++++++++++++
 tb/tb_lr_col_merge.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lr_col_merge.sv
// lr_col_merge
//
// Joins separate left and right 32-bit pixel streams into one interleaved
// LR stream. Each input word holds four 8-bit pixels (P0 in [31:24] down to
// P3 in [7:0]). Every word is decimated horizontally by two, and the two
// surviving pixels of each side are packed as {R0, L0, R1, L1}. Decimation
// either keeps the even pixels (C_DECIM_AVG = 0) or averages each pixel pair
// with a truncating 9-bit sum (C_DECIM_AVG = 1).
//
// A two-state machine keeps the streams frame-aligned:
//   SYNC : each input independently drops words whose tuser = 0 and holds a
//          word whose tuser = 1. Once both inputs hold a tuser word, the
//          machine moves to RUN. No word is consumed on that transition.
//   RUN  : words are consumed strictly in pairs. A tuser disagreement
//          consumes nothing and returns to SYNC. A tlast disagreement still
//          emits the pair, with tlast = L | R, and returns to SYNC. Both cases
//          set the sticky err_desync flag and bump the saturating err_count.
//
// Handshake semantics (all three streams): a word moves on a rising aclk
// edge where tvalid and tready are both high. A producer holding tvalid high
// keeps tdata/tlast/tuser stable until that edge. The input treadys may
// depend on the input tvalids. m_axis_lr_tvalid comes straight from a
// register and never depends on any tready.
//
// Ports
//   aclk, aresetn           clock (rising edge), async active-low reset
//   s_axis_l_*              left input stream (tdata/tvalid/tready/tlast/tuser)
//   s_axis_r_*              right input stream
//   m_axis_lr_*             interleaved output stream
//   err_desync              sticky alignment-error flag, cleared by reset only
//   err_count               alignment-error count, saturates at 255
//   dbg_state               current FSM state (0 = SYNC, 1 = RUN)
//
// Only a 32-bit data width is supported; the lane layout is fixed at four
// 8-bit pixels.

module lr_col_merge #(
  parameter int C_AXIS_LR_TDATA_WIDTH = 32,
  parameter int C_DECIM_AVG           = 0
) (
  input  logic                             aclk,
  input  logic                             aresetn,

  input  logic [C_AXIS_LR_TDATA_WIDTH-1:0] s_axis_l_tdata,
  input  logic                             s_axis_l_tvalid,
  output logic                             s_axis_l_tready,
  input  logic                             s_axis_l_tlast,
  input  logic                             s_axis_l_tuser,

  input  logic [C_AXIS_LR_TDATA_WIDTH-1:0] s_axis_r_tdata,
  input  logic                             s_axis_r_tvalid,
  output logic                             s_axis_r_tready,
  input  logic                             s_axis_r_tlast,
  input  logic                             s_axis_r_tuser,

  output logic [C_AXIS_LR_TDATA_WIDTH-1:0] m_axis_lr_tdata,
  output logic                             m_axis_lr_tvalid,
  input  logic                             m_axis_lr_tready,
  output logic                             m_axis_lr_tlast,
  output logic                             m_axis_lr_tuser,

  output logic                             err_desync,
  output logic [7:0]                       err_count,
  output logic                             dbg_state
);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Reduce one pixel pair to a single pixel. The first argument is the even
  // (more significant) pixel, which is the one kept in non-averaging mode.
  function automatic logic [7:0] decim(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (C_DECIM_AVG != 0) decim = sum[8:1];
    else                  decim = a;
  endfunction

  logic [C_AXIS_LR_TDATA_WIDTH-1:0] packed_word;

  assign packed_word = {decim(s_axis_r_tdata[31:24], s_axis_r_tdata[23:16]),
                        decim(s_axis_l_tdata[31:24], s_axis_l_tdata[23:16]),
                        decim(s_axis_r_tdata[15:8],  s_axis_r_tdata[7:0]),
                        decim(s_axis_l_tdata[15:8],  s_axis_l_tdata[7:0])};

  logic out_free;
  logic both_valid;
  logic user_mis;
  logic last_mis;
  logic fire;
  logic err_evt;

  // The output register can accept a new word when it is empty or when its
  // current word leaves on this same edge, so no bubble is inserted.
  assign out_free   = ~m_axis_lr_tvalid | m_axis_lr_tready;
  assign both_valid = s_axis_l_tvalid & s_axis_r_tvalid;
  assign user_mis   = both_valid & (s_axis_l_tuser ^ s_axis_r_tuser);
  assign last_mis   = both_valid & ~user_mis & (s_axis_l_tlast ^ s_axis_r_tlast);

  always_comb begin
    state_nxt       = state;
    s_axis_l_tready = 1'b0;
    s_axis_r_tready = 1'b0;
    fire            = 1'b0;
    err_evt         = 1'b0;
    case (state)
      ST_SYNC: begin
        // Drop anything that is not a frame start; hold a frame start.
        s_axis_l_tready = ~(s_axis_l_tvalid & s_axis_l_tuser);
        s_axis_r_tready = ~(s_axis_r_tvalid & s_axis_r_tuser);
        if (s_axis_l_tvalid & s_axis_l_tuser & s_axis_r_tvalid & s_axis_r_tuser)
          state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (user_mis) begin
          // One side is at a frame start and the other is not: consume
          // nothing and let SYNC drain the lagging side.
          err_evt   = 1'b1;
          state_nxt = ST_SYNC;
        end else if (both_valid && out_free) begin
          fire            = 1'b1;
          s_axis_l_tready = 1'b1;
          s_axis_r_tready = 1'b1;
          if (last_mis) begin
            err_evt   = 1'b1;
            state_nxt = ST_SYNC;
          end
        end
      end
      default: state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_SYNC;
    else          state <= state_nxt;
  end

  assign dbg_state = state;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_lr_tvalid <= 1'b0;
      m_axis_lr_tdata  <= '0;
      m_axis_lr_tlast  <= 1'b0;
      m_axis_lr_tuser  <= 1'b0;
    end else if (fire) begin
      m_axis_lr_tvalid <= 1'b1;
      m_axis_lr_tdata  <= packed_word;
      // Equal to L.tlast on a clean join; the OR closes the line on a
      // tlast disagreement.
      m_axis_lr_tlast  <= s_axis_l_tlast | s_axis_r_tlast;
      m_axis_lr_tuser  <= s_axis_l_tuser;
    end else if (m_axis_lr_tready) begin
      m_axis_lr_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_desync <= 1'b0;
      err_count  <= 8'd0;
    end else if (err_evt) begin
      err_desync <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_lr_col_merge.sv
// Testbench for lr_col_merge. Two instances share all inputs: dut0 keeps
// even pixels, dut1 averages pixel pairs. Expected words come from a pixel-
// level reference function and are queued in the order pairs should emerge.

module tb_lr_col_merge;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn;

  // ---------------- DUT signals ----------------
  logic [31:0] l_tdata, r_tdata;
  logic        l_tvalid, l_tlast, l_tuser;
  logic        r_tvalid, r_tlast, r_tuser;
  logic        l_tready, r_tready, l_tready1, r_tready1;
  logic        m_tready;
  logic [31:0] m0_tdata, m1_tdata;
  logic        m0_tvalid, m0_tlast, m0_tuser;
  logic        m1_tvalid, m1_tlast, m1_tuser;
  logic        err_desync0, err_desync1, dbg0, dbg1;
  logic [7:0]  err_count0, err_count1;

  lr_col_merge #(.C_AXIS_LR_TDATA_WIDTH(32), .C_DECIM_AVG(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_l_tdata(l_tdata), .s_axis_l_tvalid(l_tvalid), .s_axis_l_tready(l_tready),
    .s_axis_l_tlast(l_tlast), .s_axis_l_tuser(l_tuser),
    .s_axis_r_tdata(r_tdata), .s_axis_r_tvalid(r_tvalid), .s_axis_r_tready(r_tready),
    .s_axis_r_tlast(r_tlast), .s_axis_r_tuser(r_tuser),
    .m_axis_lr_tdata(m0_tdata), .m_axis_lr_tvalid(m0_tvalid), .m_axis_lr_tready(m_tready),
    .m_axis_lr_tlast(m0_tlast), .m_axis_lr_tuser(m0_tuser),
    .err_desync(err_desync0), .err_count(err_count0), .dbg_state(dbg0)
  );

  lr_col_merge #(.C_AXIS_LR_TDATA_WIDTH(32), .C_DECIM_AVG(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_l_tdata(l_tdata), .s_axis_l_tvalid(l_tvalid), .s_axis_l_tready(l_tready1),
    .s_axis_l_tlast(l_tlast), .s_axis_l_tuser(l_tuser),
    .s_axis_r_tdata(r_tdata), .s_axis_r_tvalid(r_tvalid), .s_axis_r_tready(r_tready1),
    .s_axis_r_tlast(r_tlast), .s_axis_r_tuser(r_tuser),
    .m_axis_lr_tdata(m1_tdata), .m_axis_lr_tvalid(m1_tvalid), .m_axis_lr_tready(m_tready),
    .m_axis_lr_tlast(m1_tlast), .m_axis_lr_tuser(m1_tuser),
    .err_desync(err_desync1), .err_count(err_count1), .dbg_state(dbg1)
  );

  // ---------------- scoreboard state ----------------
  // Source words: {tuser, tlast, tdata}.
  logic [33:0] l_src[$];
  logic [33:0] r_src[$];
  // Expected outputs: {tuser, tlast, avg-mode tdata, keep-mode tdata}.
  logic [65:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 stalled

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel-level reference: split into pixels, decimate each side by two,
  // interleave as R, L, R, L.
  function automatic logic [31:0] ref_pack(input logic [31:0] l, input logic [31:0] r,
                                           input bit avg);
    int lp[4];
    int rp[4];
    int lo[2];
    int ro[2];
    for (int k = 0; k < 4; k++) begin
      lp[k] = int'((l >> (24 - 8 * k)) & 32'hFF);
      rp[k] = int'((r >> (24 - 8 * k)) & 32'hFF);
    end
    for (int j = 0; j < 2; j++) begin
      lo[j] = avg ? (lp[2*j] + lp[2*j+1]) / 2 : lp[2*j];
      ro[j] = avg ? (rp[2*j] + rp[2*j+1]) / 2 : rp[2*j];
    end
    return {8'(ro[0]), 8'(lo[0]), 8'(ro[1]), 8'(lo[1])};
  endfunction

  function automatic logic [33:0] mkw(input bit user, input bit last, input logic [31:0] d);
    return {user, last, d};
  endfunction

  task automatic push_exp(input logic [33:0] lw, input logic [33:0] rw);
    exp_q.push_back({lw[33], lw[32] | rw[32],
                     ref_pack(lw[31:0], rw[31:0], 1'b1), ref_pack(lw[31:0], rw[31:0], 1'b0)});
  endtask

  task automatic add_pair(input logic [33:0] lw, input logic [33:0] rw);
    l_src.push_back(lw);
    r_src.push_back(rw);
    push_exp(lw, rw);
  endtask

  task automatic add_frame(input int lines, input int wpl);
    for (int ln = 0; ln < lines; ln++)
      for (int w = 0; w < wpl; w++)
        add_pair(mkw(ln == 0 && w == 0, w == wpl - 1, $urandom),
                 mkw(ln == 0 && w == 0, w == wpl - 1, $urandom));
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input bit side, input int gap_max);
    logic [33:0] w;
    int k;
    int n;
    bit hs;
    while (1) begin
      if (side == 1'b0) begin
        if (l_src.size() == 0) break;
        w = l_src.pop_front();
      end else begin
        if (r_src.size() == 0) break;
        w = r_src.pop_front();
      end
      k = $urandom_range(0, gap_max);
      if (k > 0) begin
        if (side == 1'b0) l_tvalid = 1'b0; else r_tvalid = 1'b0;
        repeat (k) @(posedge aclk);
        #1;
      end
      if (side == 1'b0) begin
        l_tvalid = 1'b1; l_tuser = w[33]; l_tlast = w[32]; l_tdata = w[31:0];
      end else begin
        r_tvalid = 1'b1; r_tuser = w[33]; r_tlast = w[32]; r_tdata = w[31:0];
      end
      n  = 0;
      hs = 1'b0;
      while (!hs && n < 300) begin
        @(negedge aclk);
        hs = (side == 1'b0) ? l_tready : r_tready;
        @(posedge aclk);
        #1;
        n++;
      end
      check(side ? "drive_hs_r" : "drive_hs_l", 32'(hs), 32'd1);
    end
    if (side == 1'b0) l_tvalid = 1'b0; else r_tvalid = 1'b0;
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        2:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic monitor();
    logic [33:0] prev;
    logic [65:0] e;
    bit stalled;
    stalled = 1'b0;
    prev    = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", 32'(m0_tvalid), 32'd1);
          check("stall_data", m0_tdata, prev[31:0]);
          check("stall_side", 32'({m0_tuser, m0_tlast}), 32'(prev[33:32]));
        end
        if (m0_tvalid && m_tready) begin
          check("out_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_data", m0_tdata, e[31:0]);
            check("out_data_avg", m1_tdata, e[63:32]);
            check("out_valid_avg", 32'(m1_tvalid), 32'd1);
            check("out_tlast", 32'(m0_tlast), 32'(e[64]));
            check("out_tuser", 32'(m0_tuser), 32'(e[65]));
          end
        end
        stalled = m0_tvalid && !m_tready;
        prev    = {m0_tuser, m0_tlast, m0_tdata};
      end
    end
  endtask

  task automatic run_streams(input int gap_max);
    int n;
    fork
      drive(1'b0, gap_max);
      drive(1'b1, gap_max);
    join
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge aclk);
      n++;
    end
    repeat (4) @(posedge aclk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    m_tready = 1'b1;
    l_tdata = '0; l_tvalid = 1'b0; l_tlast = 1'b0; l_tuser = 1'b0;
    r_tdata = '0; r_tvalid = 1'b0; r_tlast = 1'b0; r_tuser = 1'b0;
    aresetn = 1'b0;
    fork
      ready_drv();
      monitor();
    join_none

    // Reset state, with both inputs already presenting frame-start words.
    l_tvalid = 1'b1; l_tuser = 1'b1; l_tdata = 32'h11111111;
    r_tvalid = 1'b1; r_tuser = 1'b1; r_tdata = 32'h22222222;
    repeat (2) @(negedge aclk);
    check("rst_m_valid", 32'(m0_tvalid), 32'd0);
    check("rst_m_data", m0_tdata, 32'd0);
    check("rst_m_side", 32'({m0_tlast, m0_tuser}), 32'd0);
    check("rst_err_desync", 32'(err_desync0), 32'd0);
    check("rst_err_count", 32'(err_count0), 32'd0);
    check("rst_l_ready", 32'(l_tready), 32'd0);
    check("rst_r_ready", 32'(r_tready), 32'd0);
    check("rst_ready_avg", 32'({l_tready1, r_tready1}), 32'd0);
    check("rst_state", 32'({dbg0, dbg1}), 32'd0);
    check("rst_m_valid_avg", 32'(m1_tvalid), 32'd0);
    @(posedge aclk); #1;
    l_tvalid = 1'b0; r_tvalid = 1'b0; l_tuser = 1'b0; r_tuser = 1'b0;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Directed 2-word frame, always ready: exact cycle behaviour.
    push_exp(mkw(1, 0, 32'h10203040), mkw(1, 0, 32'hA0B0C0D0));
    push_exp(mkw(0, 1, 32'h50607080), mkw(0, 1, 32'hE0F00010));
    l_tvalid = 1'b1; l_tuser = 1'b1; l_tlast = 1'b0; l_tdata = 32'h10203040;
    r_tvalid = 1'b1; r_tuser = 1'b1; r_tlast = 1'b0; r_tdata = 32'hA0B0C0D0;
    @(negedge aclk);
    check("sync_hold_l", 32'(l_tready), 32'd0);
    check("sync_hold_r", 32'(r_tready), 32'd0);
    check("sync_state", 32'(dbg0), 32'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("run_state", 32'(dbg0), 32'd1);
    check("idle_cycle_valid", 32'(m0_tvalid), 32'd0);
    check("run_ready", 32'({l_tready, r_tready}), 32'd3);
    @(posedge aclk); #1;
    l_tuser = 1'b0; l_tlast = 1'b1; l_tdata = 32'h50607080;
    r_tuser = 1'b0; r_tlast = 1'b1; r_tdata = 32'hE0F00010;
    @(negedge aclk);
    check("latency_valid", 32'(m0_tvalid), 32'd1);
    check("w0_keep", m0_tdata, 32'hA010C030);
    check("w0_avg", m1_tdata, 32'hA818C838);
    check("w0_tuser", 32'(m0_tuser), 32'd1);
    @(posedge aclk); #1;
    l_tvalid = 1'b0; r_tvalid = 1'b0;
    @(negedge aclk);
    check("w1_keep", m0_tdata, 32'hE0500070);
    check("w1_avg", m1_tdata, 32'hE8580878);
    check("w1_tlast", 32'(m0_tlast), 32'd1);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("idle_after_frame", 32'(m0_tvalid), 32'd0);
    check("no_err_frame", 32'({err_desync0, err_count0}), 32'd0);
    @(posedge aclk); #1;

    // Same frame with output ready toggling every cycle.
    rdy_mode = 1;
    add_pair(mkw(1, 0, 32'h10203040), mkw(1, 0, 32'hA0B0C0D0));
    add_pair(mkw(0, 1, 32'h50607080), mkw(0, 1, 32'hE0F00010));
    run_streams(0);
    rdy_mode = 0;

    // Backpressure drops input readies; reset flushes the in-flight word.
    rdy_mode = 3;
    @(posedge aclk); #1;
    l_tvalid = 1'b1; l_tuser = 1'b1; l_tlast = 1'b0; l_tdata = 32'h01020304;
    r_tvalid = 1'b1; r_tuser = 1'b1; r_tlast = 1'b0; r_tdata = 32'h05060708;
    @(posedge aclk); #1;
    l_tuser = 1'b0; l_tdata = 32'h090A0B0C;
    r_tuser = 1'b0; r_tdata = 32'h0D0E0F10;
    @(negedge aclk);
    check("bp_valid", 32'(m0_tvalid), 32'd1);
    check("bp_ready", 32'({l_tready, r_tready}), 32'd0);
    #2;
    aresetn = 1'b0;
    #1;
    check("reset_flush", 32'(m0_tvalid), 32'd0);
    check("reset_state", 32'(dbg0), 32'd0);
    l_tvalid = 1'b0; r_tvalid = 1'b0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    rdy_mode = 0;
    @(posedge aclk); #1;

    // Left leads with garbage words after reset; right starts clean.
    for (int i = 0; i < 3; i++) l_src.push_back(mkw(0, 1'($urandom_range(0, 1)), $urandom));
    add_frame(2, 3);
    run_streams(2);
    check("garbage_no_err", 32'(err_desync0), 32'd0);

    // Randomized well-formed frames with random gaps and backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) add_frame($urandom_range(1, 3), $urandom_range(1, 4));
    run_streams(3);
    rdy_mode = 0;
    check("random_no_err", 32'({err_desync0, err_count0}), 32'd0);

    // Frame misalignment in RUN: left shows a non-start word, right a start.
    l_src.push_back(mkw(0, 0, $urandom));
    add_frame(1, 4);
    run_streams(1);
    check("tuser_mis_desync", 32'(err_desync0), 32'd1);
    check("tuser_mis_count", 32'(err_count0), 32'd1);

    // Unequal lines: left 4 words, right 3; third output closes the line.
    add_pair(mkw(1, 0, $urandom), mkw(1, 0, $urandom));
    add_pair(mkw(0, 0, $urandom), mkw(0, 0, $urandom));
    add_pair(mkw(0, 0, $urandom), mkw(0, 1, $urandom));
    l_src.push_back(mkw(0, 1, $urandom));
    add_frame(2, 2);
    run_streams(1);
    check("tlast_mis_count", 32'(err_count0), 32'd2);

    // Repeated tlast disagreements drive the counter into saturation.
    for (int i = 0; i < 252; i++) begin
      add_pair(mkw(1, 0, $urandom), mkw(1, 1, $urandom));
      l_src.push_back(mkw(0, 1, $urandom));
    end
    run_streams(0);
    check("count_254", 32'(err_count0), 32'd254);
    for (int i = 0; i < 4; i++) begin
      add_pair(mkw(1, 0, $urandom), mkw(1, 1, $urandom));
      l_src.push_back(mkw(0, 1, $urandom));
    end
    run_streams(0);
    check("count_sat", 32'(err_count0), 32'd255);
    check("count_sat_avg", 32'(err_count1), 32'd255);
    check("desync_sticky", 32'({err_desync0, err_desync1}), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
